// File: rtl/adc_range_sequencer_pkg.sv
// Purpose: shared command-bit positions, sequencer state encoding and readout field helpers
//          for the ADC range sequencer.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package adc_range_sequencer_pkg;

    // Host CSR write word (GPIO_OUT) bit positions.
    localparam int unsigned CMD_START_BIT     = 0;
    localparam int unsigned CMD_CLEAR_BIT     = 1;
    localparam int unsigned CMD_LOAD_ADDR_BIT = 2;
    localparam int unsigned RD_ADDR_LSB       = 16;
    localparam int unsigned RD_ADDR_MSB       = 20;

    // Range-monitor command word (rcGpioOut) bit positions.
    localparam int unsigned RC_LATCH_BIT = 0;
    localparam int unsigned RC_SHIFT_BIT = 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LATCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_SHIFT   = 3'd4,
        S_DONE    = 3'd5
    } seq_state_e;

    // The monitor left-justifies the sample in the low half-word; return it right-aligned.
    function automatic logic [15:0] readout_value(input logic [15:0] readout_lo,
                                                  input int unsigned adc_width);
        return readout_lo >> (16 - adc_width);
    endfunction

    // Most negative two's-complement code of an adc_width-bit sample (MSB set, rest clear).
    function automatic logic [15:0] neg_full_scale(input int unsigned adc_width);
        return 16'(1) << (adc_width - 1);
    endfunction

    // Most positive two's-complement code of an adc_width-bit sample (MSB clear, rest set).
    function automatic logic [15:0] pos_full_scale(input int unsigned adc_width);
        return (16'(1) << (adc_width - 1)) - 16'(1);
    endfunction

endpackage

// File: rtl/adc_range_sequencer.sv
// Purpose: drives the range monitor's latch/shift command sequence, buffers every min/max word
//          of a sweep, keeps sticky per-lane clip flags and serves them on CSR read ports.
// Latency: sweep = 1 + W*(SETTLE_CYCLES+1) + (W-1) + 1 cycles busy; sysData 1 cycle after address load.
// Backpressure: none; a start while busy is silently dropped, other commands always take effect.
//
// Ports:
//   sysClk / sysReset      clock and synchronous active-high reset
//   sysCsrStrobe, GPIO_OUT host command: bit0 start, bit1 clear clips, bit2 load address, [20:16] address
//   rcCsrStrobe, rcGpioOut command strobe/word to the range monitor (bit0 latch, bit1 shift)
//   rcReadout              monitor readout, sample left-justified in [15:0]
//   sysStatus              {busy, valid, 6'b0, sweep_count[7:0], clip_mask[15:0]}
//   sysData                sign-extended buffered word at the read address (0 beyond the buffer)
module adc_range_sequencer
    import adc_range_sequencer_pkg::*;
#(
    parameter int LANE_COUNT    = 8,
    parameter int ADC_WIDTH     = 14,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic        sysClk,
    input  logic        sysReset,
    input  logic        sysCsrStrobe,
    input  logic [31:0] GPIO_OUT,
    output logic        rcCsrStrobe,
    output logic [31:0] rcGpioOut,
    input  logic [31:0] rcReadout,
    output logic [31:0] sysStatus,
    output logic [31:0] sysData
);

    localparam int W     = 2 * LANE_COUNT;
    localparam int IDX_W = (W > 2) ? $clog2(W) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    seq_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic [7:0]             sweep_cnt_q, sweep_cnt_d;
    logic [LANE_COUNT-1:0]  clip_q, clip_d;
    logic [4:0]             rd_addr_q, rd_addr_d;
    logic [31:0]            data_q, data_d;
    logic                   rc_stb_q, rc_stb_d;
    logic [1:0]             rc_cmd_q, rc_cmd_d;

    // Sample buffer: even address = lane min, odd address = lane max. Not reset.
    logic [ADC_WIDTH-1:0]   buf_mem [W];
    logic                   buf_we;

    // ------------------------------------------------------------------
    // Command decode and readout field extraction
    // ------------------------------------------------------------------
    logic                   start_cmd;
    logic                   clear_cmd;
    logic                   load_cmd;
    logic [15:0]            capture_val;
    logic [ADC_WIDTH-1:0]   capture_word;
    logic                   capture_clip;
    logic [IDX_W-1:0]       lane_sel;
    logic [ADC_WIDTH-1:0]   rd_word;
    logic [15:0]            clip_status;
    logic                   unused_inputs;

    assign start_cmd    = sysCsrStrobe && GPIO_OUT[CMD_START_BIT];
    assign clear_cmd    = sysCsrStrobe && GPIO_OUT[CMD_CLEAR_BIT];
    assign load_cmd     = sysCsrStrobe && GPIO_OUT[CMD_LOAD_ADDR_BIT];

    assign capture_val  = readout_value(rcReadout[15:0], ADC_WIDTH);
    assign capture_word = capture_val[ADC_WIDTH-1:0];
    assign lane_sel     = idx_q >> 1;

    // Odd buffer addresses hold max words, which clip at positive full scale;
    // even addresses hold min words, which clip at negative full scale.
    assign capture_clip = idx_q[0] ? (capture_val == pos_full_scale(ADC_WIDTH))
                                   : (capture_val == neg_full_scale(ADC_WIDTH));

    assign unused_inputs = ^{GPIO_OUT[31:21], GPIO_OUT[15:3], rcReadout[31:16]};

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        sweep_cnt_d = sweep_cnt_q;
        buf_we      = 1'b0;

        // Clear is applied before any capture of the same cycle so a clip
        // detected by that capture survives.
        clip_d      = clear_cmd ? '0 : clip_q;
        rd_addr_d   = load_cmd ? GPIO_OUT[RD_ADDR_MSB:RD_ADDR_LSB] : rd_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_cmd) begin
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    idx_d   = '0;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                cnt_d   = SETTLE_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Loaded with SETTLE_CYCLES-1 and exits on zero: SETTLE_CYCLES cycles here.
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                buf_we = 1'b1;
                if (capture_clip) begin
                    clip_d = clip_d | (LANE_COUNT'(1) << lane_sel);
                end
                // The final word is never shifted past, leaving the monitor parked on it.
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                cnt_d   = SETTLE_LOAD;
                state_d = S_WAIT;
            end
            S_DONE: begin
                busy_d      = 1'b0;
                valid_d     = 1'b1;
                sweep_cnt_d = sweep_cnt_q + 8'd1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Command outputs are registered from the next state so the strobe
        // lines up exactly with the LATCH/SHIFT cycle and is glitch-free.
        rc_stb_d = (state_d == S_LATCH) || (state_d == S_SHIFT);
        rc_cmd_d = '0;
        if (state_d == S_LATCH) begin
            rc_cmd_d[RC_LATCH_BIT] = 1'b1;
        end
        if (state_d == S_SHIFT) begin
            rc_cmd_d[RC_SHIFT_BIT] = 1'b1;
        end

        // Read path uses the incoming address so a load is visible one cycle
        // later, and re-reads every cycle so it follows buffer writes.
        rd_word = buf_mem[rd_addr_d[IDX_W-1:0]];
        if ({27'd0, rd_addr_d} < 32'(W)) begin
            data_d = {{(32-ADC_WIDTH){rd_word[ADC_WIDTH-1]}}, rd_word};
        end else begin
            data_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            sweep_cnt_q <= '0;
            clip_q      <= '0;
            rd_addr_q   <= '0;
            data_q      <= '0;
            rc_stb_q    <= 1'b0;
            rc_cmd_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            sweep_cnt_q <= sweep_cnt_d;
            clip_q      <= clip_d;
            rd_addr_q   <= rd_addr_d;
            data_q      <= data_d;
            rc_stb_q    <= rc_stb_d;
            rc_cmd_q    <= rc_cmd_d;
        end
    end

    always_ff @(posedge sysClk) begin
        if (buf_we && !sysReset) begin
            buf_mem[idx_q] <= capture_word;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        clip_status                 = '0;
        clip_status[LANE_COUNT-1:0] = clip_q;
    end

    assign rcCsrStrobe = rc_stb_q;
    assign rcGpioOut   = {30'd0, rc_cmd_q};
    assign sysStatus   = {busy_q, valid_q, 6'd0, sweep_cnt_q, clip_status};
    assign sysData     = data_q;

endmodule
